// File: rtl/codec_input_capture.sv
// Receive-side capture of codec ADC samples: one sample per frame edge,
// buffered in a small FIFO and handed downstream over valid/ack.
module codec_input_capture #(
   parameter int WIDTH      = 16,
   parameter int DEPTH_LOG2 = 2,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  new_frame,
   input  logic [WIDTH-1:0]      adc_sample_in,
   input  logic                  enable,
   output logic [WIDTH-1:0]      sample_out,
   output logic                  sample_valid,
   input  logic                  sample_ack,
   output logic [DEPTH_LOG2:0]   fifo_level,
   output logic [CNT_WIDTH-1:0]  overflow_count
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   LVL_ONE    = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = CNT_WIDTH'(1);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   level;
   logic                  nf_q;

   logic frame_strobe;
   logic candidate;
   logic full;
   logic pop;
   logic wr_en;
   logic drop;

   // Handshake: sample_valid is high whenever the FIFO holds data and then
   // sample_out shows the head; the head is consumed on any clock edge where
   // sample_ack and sample_valid are both high. Ack without valid is ignored.
   always_comb begin
      frame_strobe = new_frame & ~nf_q;
      candidate    = frame_strobe & enable;
      full         = (level == FULL_LEVEL);
      pop          = sample_ack & sample_valid;
      // A full FIFO can still accept when the head leaves on the same edge.
      wr_en        = candidate & (~full | pop);
      drop         = candidate & full & ~pop;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         nf_q           <= 1'b1;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         level          <= '0;
         overflow_count <= '0;
      end else begin
         nf_q <= new_frame;
         if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
         if (wr_en && !pop)
            level <= level + LVL_ONE;
         else if (!wr_en && pop)
            level <= level - LVL_ONE;
         if (drop && (overflow_count != '1))
            overflow_count <= overflow_count + CNT_ONE;
      end
   end

   // Storage needs no reset: empty slots are masked from sample_out.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= adc_sample_in;
   end

   always_comb begin
      sample_valid = (level != '0);
      sample_out   = sample_valid ? mem[rd_ptr] : '0;
      fifo_level   = level;
   end

endmodule

// File: tb/tb_codec_input_capture.sv
// Directed bench for codec_input_capture: frame detect, FIFO order,
// overflow drop/saturation, enable gating and asynchronous reset.
module tb_codec_input_capture;

   logic        clk;
   logic        reset;
   logic        new_frame;
   logic [15:0] adc_sample_in;
   logic        enable;
   logic [15:0] sample_out;
   logic        sample_valid;
   logic        sample_ack;
   logic [2:0]  fifo_level;
   logic [7:0]  overflow_count;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q[$];

   codec_input_capture #(.WIDTH(16), .DEPTH_LOG2(2), .CNT_WIDTH(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .new_frame      (new_frame),
      .adc_sample_in  (adc_sample_in),
      .enable         (enable),
      .sample_out     (sample_out),
      .sample_valid   (sample_valid),
      .sample_ack     (sample_ack),
      .fifo_level     (fifo_level),
      .overflow_count (overflow_count)
   );

   // clock/reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset(input logic nf_during);
      reset         = 1'b0;
      new_frame     = nf_during;
      sample_ack    = 1'b0;
      enable        = 1'b1;
      adc_sample_in = 16'(($urandom_range(0, 65535)));
      exp_q.delete();
      tick();
      tick();
      reset = 1'b1;
   endtask

   // driver: one frame, new_frame held for hold cycles, then one low cycle
   task automatic drive_frame(input logic [15:0] smp, input int hold);
      new_frame     = 1'b1;
      adc_sample_in = smp;
      tick();
      for (int i = 1; i < hold; i++) begin
         adc_sample_in = 16'(($urandom_range(0, 65535)));
         tick();
      end
      new_frame = 1'b0;
      tick();
   endtask

   // scoreboard: pop one entry with ack and compare against the expected head
   task automatic drain_one(input string name);
      logic [15:0] exp;
      exp = exp_q.pop_front();
      checks++;
      if (sample_valid !== 1'b1 || sample_out !== exp) begin
         errors++;
         $display("FAIL %s: got valid=%0b out=%h expected valid=1 out=%h", name, sample_valid, sample_out, exp);
      end
      sample_ack = 1'b1;
      tick();
      sample_ack = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset(1'b0);
      checks++;
      if (fifo_level !== 3'd0 || sample_valid !== 1'b0 || sample_out !== 16'h0 || overflow_count !== 8'h0) begin
         errors++;
         $display("FAIL reset_state: got level=%0d valid=%0b out=%h ovf=%h expected all 0", fifo_level, sample_valid, sample_out, overflow_count);
      end
      tick();
   endtask

   task automatic test_single_capture();
      apply_reset(1'b0);
      tick();
      new_frame     = 1'b1;
      adc_sample_in = 16'h1234;
      checks++;
      if (sample_valid !== 1'b0) begin
         errors++;
         $display("FAIL capture_before_edge: got valid=%0b expected 0", sample_valid);
      end
      tick();
      checks++;
      if (sample_valid !== 1'b1 || sample_out !== 16'h1234 || fifo_level !== 3'd1) begin
         errors++;
         $display("FAIL capture_latency: got valid=%0b out=%h level=%0d expected 1 1234 1", sample_valid, sample_out, fifo_level);
      end
      adc_sample_in = 16'hDEAD;
      tick();
      adc_sample_in = 16'hBEEF;
      tick();
      new_frame = 1'b0;
      tick();
      checks++;
      if (fifo_level !== 3'd1 || sample_out !== 16'h1234) begin
         errors++;
         $display("FAIL capture_held_frame: got level=%0d out=%h expected 1 1234", fifo_level, sample_out);
      end
   endtask

   task automatic test_frame_at_reset_release();
      apply_reset(1'b1);
      tick();
      tick();
      tick();
      checks++;
      if (fifo_level !== 3'd0) begin
         errors++;
         $display("FAIL release_high_frame: got level=%0d expected 0", fifo_level);
      end
      new_frame = 1'b0;
      tick();
      drive_frame(16'hAAAA, 1);
      checks++;
      if (fifo_level !== 3'd1 || sample_out !== 16'hAAAA) begin
         errors++;
         $display("FAIL release_next_frame: got level=%0d out=%h expected 1 aaaa", fifo_level, sample_out);
      end
   endtask

   task automatic test_overflow_drain();
      apply_reset(1'b0);
      tick();
      for (int i = 1; i <= 5; i++) begin
         drive_frame(16'(i), $urandom_range(1, 3));
         if (exp_q.size() < 4) exp_q.push_back(16'(i));
      end
      checks++;
      if (fifo_level !== 3'd4 || overflow_count !== 8'd1) begin
         errors++;
         $display("FAIL overflow_one: got level=%0d ovf=%0d expected 4 1", fifo_level, overflow_count);
      end
      for (int i = 0; i < 4; i++) drain_one("overflow_drain_order");
      checks++;
      if (sample_valid !== 1'b0 || sample_out !== 16'h0 || fifo_level !== 3'd0) begin
         errors++;
         $display("FAIL drained_empty: got valid=%0b out=%h level=%0d expected 0 0 0", sample_valid, sample_out, fifo_level);
      end
   endtask

   task automatic test_back_to_back();
      apply_reset(1'b0);
      tick();
      for (int i = 1; i <= 4; i++) begin
         drive_frame(16'(i), 1);
         exp_q.push_back(16'(i));
      end
      checks++;
      if (sample_out !== 16'd1) begin
         errors++;
         $display("FAIL full_head: got %h expected 0001", sample_out);
      end
      new_frame     = 1'b1;
      adc_sample_in = 16'd9;
      sample_ack    = 1'b1;
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(16'd9);
      new_frame  = 1'b0;
      sample_ack = 1'b0;
      tick();
      checks++;
      if (fifo_level !== 3'd4 || overflow_count !== 8'd0) begin
         errors++;
         $display("FAIL full_pop_write: got level=%0d ovf=%0d expected 4 0", fifo_level, overflow_count);
      end
      for (int i = 0; i < 4; i++) drain_one("full_pop_write_order");
   endtask

   task automatic test_enable();
      apply_reset(1'b0);
      enable = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) drive_frame(16'hF00 + 16'(i), 1);
      checks++;
      if (fifo_level !== 3'd0 || overflow_count !== 8'd0 || sample_valid !== 1'b0) begin
         errors++;
         $display("FAIL enable_off: got level=%0d ovf=%0d valid=%0b expected 0 0 0", fifo_level, overflow_count, sample_valid);
      end
      sample_ack = 1'b1;
      tick();
      tick();
      sample_ack = 1'b0;
      enable     = 1'b1;
      drive_frame(16'h5A5A, 1);
      exp_q.push_back(16'h5A5A);
      drive_frame(16'hB00B, 2);
      exp_q.push_back(16'hB00B);
      checks++;
      if (fifo_level !== 3'd2) begin
         errors++;
         $display("FAIL enable_on_level: got %0d expected 2", fifo_level);
      end
      enable = 1'b0;
      drive_frame(16'h7777, 1);
      drain_one("enable_drop_drain");
      drain_one("enable_drop_drain");
      checks++;
      if (sample_valid !== 1'b0) begin
         errors++;
         $display("FAIL enable_drop_empty: got valid=%0b expected 0", sample_valid);
      end
      enable = 1'b1;
   endtask

   task automatic test_saturation_async_reset();
      apply_reset(1'b0);
      tick();
      for (int i = 1; i <= 4; i++) drive_frame(16'h100 + 16'(i), 1);
      drive_frame(16'hEEEE, 1);
      checks++;
      if (overflow_count !== 8'd1 || sample_out !== 16'h101) begin
         errors++;
         $display("FAIL sat_first_drop: got ovf=%0d out=%h expected 1 0101", overflow_count, sample_out);
      end
      for (int i = 2; i <= 255; i++) drive_frame(16'(i), 1);
      checks++;
      if (overflow_count !== 8'hFF) begin
         errors++;
         $display("FAIL sat_reach: got %h expected ff", overflow_count);
      end
      for (int i = 256; i <= 300; i++) drive_frame(16'(i), 1);
      checks++;
      if (overflow_count !== 8'hFF || fifo_level !== 3'd4) begin
         errors++;
         $display("FAIL sat_hold: got ovf=%h level=%0d expected ff 4", overflow_count, fifo_level);
      end
      new_frame     = 1'b1;
      adc_sample_in = 16'hCAFE;
      #3;
      reset = 1'b0;
      #1;
      checks++;
      if (fifo_level !== 3'd0 || sample_valid !== 1'b0 || sample_out !== 16'h0 || overflow_count !== 8'h0) begin
         errors++;
         $display("FAIL async_reset: got level=%0d valid=%0b out=%h ovf=%h expected all 0", fifo_level, sample_valid, sample_out, overflow_count);
      end
      tick();
      reset = 1'b1;
      tick();
      checks++;
      if (fifo_level !== 3'd0) begin
         errors++;
         $display("FAIL reset_pending_lost: got level=%0d expected 0", fifo_level);
      end
      new_frame = 1'b0;
      tick();
   endtask

   initial begin
      reset         = 1'b0;
      new_frame     = 1'b0;
      adc_sample_in = '0;
      enable        = 1'b1;
      sample_ack    = 1'b0;
      test_reset();
      test_single_capture();
      test_frame_at_reset_release();
      test_overflow_drain();
      test_back_to_back();
      test_enable();
      test_saturation_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/codec_input_capture.md
Name: codec_input_capture

Overview:
- Receive side of the codec audio path: captures one ADC sample per codec frame, aligned to the raw new_frame signal from adau1761_codec.
- Buffers captured samples in a small FIFO.
- Hands samples to a downstream consumer (recorder, effects or loopback logic) over a valid/ack handshake.
- Counts frames dropped because the FIFO was full.

Parameters:
WIDTH, 16, sample width in bits
DEPTH_LOG2, 2, log2 of FIFO depth (default depth 4)
CNT_WIDTH, 8, width of the overflow counter

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
new_frame  input  1  raw frame signal from codec; level, may stay high for multiple cycles
adc_sample_in  input  WIDTH  codec ADC sample; valid in the cycle new_frame is high
enable  input  1  capture enable; 0 = ignore frames
sample_out  output  WIDTH  FIFO head sample
sample_valid  output  1  high while FIFO is not empty
sample_ack  input  1  consumer pops the head when high with sample_valid
fifo_level  output  DEPTH_LOG2+1  number of stored samples, 0..DEPTH
overflow_count  output  CNT_WIDTH  saturating count of dropped frames

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty; read and write pointers 0.
  - sample_valid=0, sample_out=0, fifo_level=0, overflow_count=0.
  - Frame-edge register nf_q=1, so new_frame already high at reset release is not a frame.
- Frame detect:
  - nf_q <= new_frame every cycle.
  - frame_strobe = new_frame & ~nf_q (combinational).
  - A frame held high N cycles gives exactly one strobe.
- Capture:
  - On the clk edge with frame_strobe=1 and enable=1, adc_sample_in is the write candidate.
  - With enable=0, strobes are ignored: no write, no overflow count.
- Write:
  - Candidate accepted if fifo_level<DEPTH, or if fifo_level==DEPTH and a pop occurs on the same edge.
  - On accept: mem[wr_ptr] <= sample, wr_ptr increments modulo DEPTH.
- Drop:
  - Candidate with fifo_level==DEPTH and no same-edge pop is discarded.
  - FIFO contents are unchanged.
  - overflow_count increments, saturating at all-ones.
- Pop:
  - pop = sample_ack & sample_valid; rd_ptr increments modulo DEPTH.
  - sample_ack while sample_valid=0 is ignored.
- Outputs:
  - sample_out = mem[rd_ptr] when not empty; forced to 0 when empty.
  - sample_valid = (fifo_level != 0).
  - Order is strictly FIFO.
- Level:
  - fifo_level += write − pop per edge.
  - Simultaneous write and pop leaves the level unchanged; valid at any level, including empty-with-write is impossible to pop.
  - Empty plus write: the sample appears on sample_out with sample_valid=1 on the cycle after the capturing edge (1-cycle latency).
- Pointers: DEPTH_LOG2 bits, natural wrap. The level counter is separate and disambiguates full from empty.
- Mid-operation reset: all stored samples discarded; a pending strobe in the same cycle is lost.
- Enable falling mid-stream: already-buffered samples still drain normally.

Test Plan:
1. Reset, enable=1; pulse new_frame high for 3 cycles with adc_sample_in=16'h1234; hold sample_ack=0 -> one write only; sample_valid=1 and sample_out=16'h1234 one cycle after the rising edge; fifo_level=1.
2. Release reset with new_frame already high -> no capture (fifo_level=0) until new_frame goes low then high.
3. Five frames with samples 1,2,3,4,5, no ack -> fifo_level=4; overflow_count=1; then ack for 4 cycles -> sample_out reads 1,2,3,4, then sample_valid=0 and sample_out=0.
4. FIFO full (1..4); frame with sample 9 on the same edge as a pop -> no drop, overflow_count unchanged, fifo_level stays 4; subsequent pops read 2,3,4,9.
5. enable=0, 3 frames -> fifo_level=0, overflow_count=0; sample_ack pulses while empty -> no pointer change (the next capture reads back correctly).
6. Full FIFO, 300 further frames, no ack -> overflow_count saturates at 8'hFF; assert reset mid-burst -> all outputs 0 immediately, asynchronously.
